multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit and instruction register for the 24-bit, 8-register MIPS-style core. It fetches a 24-bit instruction, decodes it, and sequences FETCH/DECODE/EXEC/MEM/WB. It drives the register file's Ra/Rb/Rw/enWrite directly, and drives the ALU, memory and PC datapath controls. It sits directly upstream of the register file and paces every register read and write.

## Interface
- No parameters; widths fixed: data 24, register address 3, retired-instruction counter 16.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- instr  in  24  instruction word from memory; sampled in FETCH when mem_ready=1.
- mem_ready  in  1  memory acknowledge for the current mem_read/mem_write request.
- zero  in  1  ALU zero flag; valid in EXEC.
- Ra, Rb  out  3  register-file read addresses (rs, rt).
- Rw  out  3  register-file write address (rd).
- enWrite  out  1  register-file write enable.
- imm_ext  out  24  sign-extended imm[10:0] of the current IR.
- alu_op  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR.
- alu_src_b  out  1  ALU B operand: 0 BusB, 1 imm_ext.
- mem_read, mem_write  out  1  memory request strobes.
- wb_sel  out  1  write-back data source: 0 ALU result, 1 memory data.
- ir_write  out  1  instruction latched this cycle (informational).
- pc_write  out  1  PC update enable.
- pc_src  out  2  next-PC select: 0 PC+1, 1 PC+1+imm_ext, 2 imm_ext.
- state  out  3  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- retired  out  16  count of completed instructions.

## Operation
- IR format: op[23:20], rd[19:17], rs[16:14], rt[13:11], imm[10:0].
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: rd = rs op rt.
  - 4 ADDI: rd = rs + imm.
  - 5 LW: rd = mem[rs + imm].
  - 6 SW: mem[rs + imm] = rt.
  - 7 BEQ: if rs == rt, PC = PC+1+imm.
  - 8 J: PC = imm_ext.
  - 9–15: illegal.
- Ra = IR.rs, Rb = IR.rt, Rw = IR.rd at all times outside reset. imm_ext = {{13{imm[10]}}, imm}.
- FETCH:
  - mem_read = 1.
  - Hold FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, IR <= instr, go to DECODE.
- DECODE:
  - Ra/Rb are presented from the new IR; the register file latches BusA/BusB on this edge.
  - Illegal op: illegal = 1, go to FETCH, IR unchanged, retired unchanged.
  - Otherwise go to EXEC.
- EXEC:
  - ADD/SUB/AND/OR: alu_op per opcode, alu_src_b = 0, go to WB.
  - ADDI/LW/SW: alu_op = 0, alu_src_b = 1. ADDI goes to WB; LW/SW go to MEM.
  - BEQ: alu_op = 1, alu_src_b = 0, pc_src = 1, pc_write = zero, go to FETCH.
  - J: pc_src = 2, pc_write = 1, go to FETCH.
- MEM:
  - LW: mem_read = 1. SW: mem_write = 1.
  - Hold MEM until mem_ready = 1; then LW goes to WB, SW goes to FETCH.
- WB:
  - enWrite = (rd != 0); R0 writes are suppressed here, not in the register file.
  - wb_sel = 1 for LW, else 0.
  - Go to FETCH.
- Retirement: retired increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps at 0xFFFF → 0.
- All unlisted outputs are 0 in each state.

## Timing
- Reset low (asynchronous):
  - state = FETCH, IR = 0, retired = 0.
  - Every control output is forced to 0 combinationally while reset is low, including mem_read, Ra, Rb, Rw and imm_ext.
- After reset release: mem_read = 1 in the first cycle.
- Outputs are combinational from state and IR. ir_write and pc_write in FETCH additionally depend on mem_ready.
- Latency with mem_ready tied to 1:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/J: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-instruction: the instruction is abandoned, no enWrite or mem_write is issued afterwards, and fetch restarts.
- mem_ready outside FETCH/MEM: ignored.

## Test plan
- Reset, release with mem_ready = 1, instr = 0x065000 (ADD r3, r1, r2):
  - State sequence is 0, 1, 2, 4, 0.
  - In DECODE: Ra = 1, Rb = 2.
  - In WB: Rw = 3, enWrite = 1, wb_sel = 0.
  - retired = 1.
- instr = 0x5A4004 (LW r5, 4(r1)), mem_ready held low for 2 cycles in both FETCH and MEM:
  - imm_ext = 0x000004, alu_src_b = 1.
  - Total 9 cycles; WB shows wb_sel = 1, Rw = 5, enWrite = 1.
- instr = 0x7057FE (BEQ r1, r2, −2):
  - imm_ext = 0xFFFFFE.
  - zero = 1 gives pc_write = 1, pc_src = 1 in EXEC; zero = 0 gives pc_write = 0.
  - Both cases return to FETCH after 3 cycles.
- instr = 0x404001 (ADDI r0, r1, 1): WB has Rw = 0, enWrite = 0; retired still increments.
- instr = 0xF00000:
  - illegal pulses for 1 cycle in DECODE, then FETCH.
  - retired is unchanged; no enWrite, no mem_write.
- SW with reset pulsed low during MEM:
  - mem_write drops immediately and all outputs are 0 during reset.
  - After release: state = 0, retired = 0, mem_read = 1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control unit and the datapath: instruction/memory handshake in,
// register-file, ALU, memory and PC controls out.
interface multicycle_control_if;
  logic [23:0] instr;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  Ra;
  logic [2:0]  Rb;
  logic [2:0]  Rw;
  logic        enWrite;
  logic [23:0] imm_ext;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic        mem_read;
  logic        mem_write;
  logic        wb_sel;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  instr, mem_ready, zero,
    output Ra, Rb, Rw, enWrite, imm_ext, alu_op, alu_src_b, mem_read, mem_write,
           wb_sel, ir_write, pc_write, pc_src, state, illegal, retired
  );

  modport slave (
    output instr, mem_ready, zero,
    input  Ra, Rb, Rw, enWrite, imm_ext, alu_op, alu_src_b, mem_read, mem_write,
           wb_sel, ir_write, pc_write, pc_src, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer and IR for the 24-bit core; 3-5 cycles per instruction.
// Stalls in FETCH and MEM until mem_ready; outputs combinational from state/IR, forced to 0 in reset.
module multicycle_control (
  input  logic               clk,
  input  logic               reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [10:0] imm;
  } ir_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  state_e      state_q, state_d;
  ir_t         ir_q, ir_d;
  logic [15:0] retired_q, retired_d;

  logic [2:0]  alu_op_c;
  logic        alu_src_b_c, mem_read_c, mem_write_c, wb_sel_c;
  logic        ir_write_c, pc_write_c, en_write_c, illegal_c;
  logic [1:0]  pc_src_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    alu_op_c    = ALU_ADD;
    alu_src_b_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    wb_sel_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'd0;
    en_write_c  = 1'b0;
    illegal_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          ir_d       = bus.instr;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q.op > OP_J) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ir_q.op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_op_c = ir_q.op[2:0];
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_b_c = 1'b1;
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b_c = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c   = ALU_SUB;
            pc_src_c   = 2'd1;
            pc_write_c = bus.zero;
            state_d    = S_FETCH;
          end
          default: begin
            // J; illegal opcodes never reach EXEC
            pc_src_c   = 2'd2;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_read_c  = (ir_q.op == OP_LW);
        mem_write_c = (ir_q.op != OP_LW);
        if (bus.mem_ready) begin
          state_d = (ir_q.op == OP_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        // R0 is hardwired: the write is dropped here rather than in the register file
        en_write_c = (ir_q.rd != 3'd0);
        wb_sel_c   = (ir_q.op == OP_LW);
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  assign bus.Ra        = reset ? ir_q.rs : 3'd0;
  assign bus.Rb        = reset ? ir_q.rt : 3'd0;
  assign bus.Rw        = reset ? ir_q.rd : 3'd0;
  assign bus.imm_ext   = reset ? {{13{ir_q.imm[10]}}, ir_q.imm} : 24'd0;
  assign bus.enWrite   = reset & en_write_c;
  assign bus.alu_op    = reset ? alu_op_c : 3'd0;
  assign bus.alu_src_b = reset & alu_src_b_c;
  assign bus.mem_read  = reset & mem_read_c;
  assign bus.mem_write = reset & mem_write_c;
  assign bus.wb_sel    = reset & wb_sel_c;
  assign bus.ir_write  = reset & ir_write_c;
  assign bus.pc_write  = reset & pc_write_c;
  assign bus.pc_src    = reset ? pc_src_c : 2'd0;
  assign bus.illegal   = reset & illegal_c;
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle table plus a reset-during-SW sequence.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rw;
    logic        en;
    logic [2:0]  aop;
    logic        asb;
    logic        mr;
    logic        mw;
    logic        wbs;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        ill;
    logic [15:0] ret;
    logic [23:0] imm;
  } obs_t;

  typedef struct {
    logic [23:0] instr;
    logic        rdy;
    logic        z;
    obs_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.st  = bus.state;     o.ra  = bus.Ra;       o.rb  = bus.Rb;
    o.rw  = bus.Rw;        o.en  = bus.enWrite;  o.aop = bus.alu_op;
    o.asb = bus.alu_src_b; o.mr  = bus.mem_read; o.mw  = bus.mem_write;
    o.wbs = bus.wb_sel;    o.irw = bus.ir_write; o.pcw = bus.pc_write;
    o.pcs = bus.pc_src;    o.ill = bus.illegal;  o.ret = bus.retired;
    o.imm = bus.imm_ext;
    return o;
  endfunction

  // Args: instr rdy zero | state Ra Rb Rw | enWrite alu_op alu_src_b | mem_read mem_write wb_sel
  //       | ir_write pc_write pc_src | illegal | retired | imm_ext
  function automatic vec_t mk(int instr, int rdy, int z, int st, int ra, int rb, int rw,
                              int en, int aop, int asb, int mr, int mw, int wbs,
                              int irw, int pcw, int pcs, int ill, int ret, int imm);
    vec_t v;
    v.instr = 24'(instr); v.rdy = 1'(rdy); v.z = 1'(z);
    v.exp.st  = 3'(st);  v.exp.ra  = 3'(ra);  v.exp.rb  = 3'(rb);  v.exp.rw = 3'(rw);
    v.exp.en  = 1'(en);  v.exp.aop = 3'(aop); v.exp.asb = 1'(asb);
    v.exp.mr  = 1'(mr);  v.exp.mw  = 1'(mw);  v.exp.wbs = 1'(wbs);
    v.exp.irw = 1'(irw); v.exp.pcw = 1'(pcw); v.exp.pcs = 2'(pcs);
    v.exp.ill = 1'(ill); v.exp.ret = 16'(ret); v.exp.imm = 24'(imm);
    return v;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d ra=%0d rb=%0d rw=%0d en=%0b aop=%0d asb=%0b mr=%0b mw=%0b wbs=%0b irw=%0b pcw=%0b pcs=%0d ill=%0b ret=%0d imm=%h | want st=%0d ra=%0d rb=%0d rw=%0d en=%0b aop=%0d asb=%0b mr=%0b mw=%0b wbs=%0b irw=%0b pcw=%0b pcs=%0d ill=%0b ret=%0d imm=%h",
               name, act.st, act.ra, act.rb, act.rw, act.en, act.aop, act.asb, act.mr, act.mw,
               act.wbs, act.irw, act.pcw, act.pcs, act.ill, act.ret, act.imm,
               exp.st, exp.ra, exp.rb, exp.rw, exp.en, exp.aop, exp.asb, exp.mr, exp.mw,
               exp.wbs, exp.irw, exp.pcw, exp.pcs, exp.ill, exp.ret, exp.imm);
    end
  endtask

  task automatic drive(input logic [23:0] instr, input logic rdy, input logic z);
    bus.instr     = instr;
    bus.mem_ready = rdy;
    bus.zero      = z;
  endtask

  initial begin
    vec_t v;

    // ADD r3,r1,r2
    vecs.push_back(mk('h065000,1,0, 0,0,0,0, 0,0,0, 1,0,0, 1,1,0, 0, 0, 'h0));
    vecs.push_back(mk('h065000,1,0, 1,1,2,3, 0,0,0, 0,0,0, 0,0,0, 0, 0, 'h0));
    vecs.push_back(mk('h065000,1,0, 2,1,2,3, 0,0,0, 0,0,0, 0,0,0, 0, 0, 'h0));
    vecs.push_back(mk('h065000,1,0, 4,1,2,3, 1,0,0, 0,0,0, 0,0,0, 0, 0, 'h0));
    // LW r5,4(r1) with two wait cycles in FETCH and in MEM: 9 cycles
    vecs.push_back(mk('h5A4004,0,0, 0,1,2,3, 0,0,0, 1,0,0, 0,0,0, 0, 1, 'h0));
    vecs.push_back(mk('h5A4004,0,0, 0,1,2,3, 0,0,0, 1,0,0, 0,0,0, 0, 1, 'h0));
    vecs.push_back(mk('h5A4004,1,0, 0,1,2,3, 0,0,0, 1,0,0, 1,1,0, 0, 1, 'h0));
    vecs.push_back(mk('h5A4004,1,0, 1,1,0,5, 0,0,0, 0,0,0, 0,0,0, 0, 1, 'h4));
    vecs.push_back(mk('h5A4004,1,0, 2,1,0,5, 0,0,1, 0,0,0, 0,0,0, 0, 1, 'h4));
    vecs.push_back(mk('h5A4004,0,0, 3,1,0,5, 0,0,0, 1,0,0, 0,0,0, 0, 1, 'h4));
    vecs.push_back(mk('h5A4004,0,0, 3,1,0,5, 0,0,0, 1,0,0, 0,0,0, 0, 1, 'h4));
    vecs.push_back(mk('h5A4004,1,0, 3,1,0,5, 0,0,0, 1,0,0, 0,0,0, 0, 1, 'h4));
    vecs.push_back(mk('h5A4004,1,0, 4,1,0,5, 1,0,0, 0,0,1, 0,0,0, 0, 1, 'h4));
    // BEQ r1,r2,-2 taken
    vecs.push_back(mk('h7057FE,1,0, 0,1,0,5, 0,0,0, 1,0,0, 1,1,0, 0, 2, 'h4));
    vecs.push_back(mk('h7057FE,1,1, 1,1,2,0, 0,0,0, 0,0,0, 0,0,0, 0, 2, 'hFFFFFE));
    vecs.push_back(mk('h7057FE,1,1, 2,1,2,0, 0,1,0, 0,0,0, 0,1,1, 0, 2, 'hFFFFFE));
    // BEQ not taken
    vecs.push_back(mk('h7057FE,1,0, 0,1,2,0, 0,0,0, 1,0,0, 1,1,0, 0, 3, 'hFFFFFE));
    vecs.push_back(mk('h7057FE,1,0, 1,1,2,0, 0,0,0, 0,0,0, 0,0,0, 0, 3, 'hFFFFFE));
    vecs.push_back(mk('h7057FE,1,0, 2,1,2,0, 0,1,0, 0,0,0, 0,0,1, 0, 3, 'hFFFFFE));
    // ADDI r0,r1,1: write to r0 suppressed, still retires
    vecs.push_back(mk('h404001,1,0, 0,1,2,0, 0,0,0, 1,0,0, 1,1,0, 0, 4, 'hFFFFFE));
    vecs.push_back(mk('h404001,1,0, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 4, 'h1));
    vecs.push_back(mk('h404001,1,0, 2,1,0,0, 0,0,1, 0,0,0, 0,0,0, 0, 4, 'h1));
    vecs.push_back(mk('h404001,1,0, 4,1,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 4, 'h1));
    // illegal opcode 15: pulse in DECODE, back to FETCH, no retire
    vecs.push_back(mk('hF00000,1,0, 0,1,0,0, 0,0,0, 1,0,0, 1,1,0, 0, 5, 'h1));
    vecs.push_back(mk('hF00000,1,0, 1,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1, 5, 'h0));
    // J 5
    vecs.push_back(mk('h800005,1,0, 0,0,0,0, 0,0,0, 1,0,0, 1,1,0, 0, 5, 'h0));
    vecs.push_back(mk('h800005,1,0, 1,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 5, 'h5));
    vecs.push_back(mk('h800005,1,0, 2,0,0,0, 0,0,0, 0,0,0, 0,1,2, 0, 5, 'h5));
    // OR r7,r6,r5 after one FETCH wait
    vecs.push_back(mk('h3FA800,0,0, 0,0,0,0, 0,0,0, 1,0,0, 0,0,0, 0, 6, 'h5));
    vecs.push_back(mk('h3FA800,1,0, 0,0,0,0, 0,0,0, 1,0,0, 1,1,0, 0, 6, 'h5));
    vecs.push_back(mk('h3FA800,1,0, 1,6,5,7, 0,0,0, 0,0,0, 0,0,0, 0, 6, 'h0));
    vecs.push_back(mk('h3FA800,1,0, 2,6,5,7, 0,3,0, 0,0,0, 0,0,0, 0, 6, 'h0));
    vecs.push_back(mk('h3FA800,1,0, 4,6,5,7, 1,0,0, 0,0,0, 0,0,0, 0, 6, 'h0));
    // SUB r2,r3,r4 with mem_ready low in DECODE/EXEC (ignored there)
    vecs.push_back(mk('h14E000,1,0, 0,6,5,7, 0,0,0, 1,0,0, 1,1,0, 0, 7, 'h0));
    vecs.push_back(mk('h14E000,0,0, 1,3,4,2, 0,0,0, 0,0,0, 0,0,0, 0, 7, 'h0));
    vecs.push_back(mk('h14E000,0,0, 2,3,4,2, 0,1,0, 0,0,0, 0,0,0, 0, 7, 'h0));
    vecs.push_back(mk('h14E000,1,0, 4,3,4,2, 1,0,0, 0,0,0, 0,0,0, 0, 7, 'h0));
    vecs.push_back(mk('h605003,0,0, 0,3,4,2, 0,0,0, 1,0,0, 0,0,0, 0, 8, 'h0));

    reset = 1'b0;
    drive(24'h065000, 1'b1, 1'b0);
    #1;
    check_obs("in_reset", '0);
    @(negedge clk);
    check_obs("in_reset_after_edge", '0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].rdy, vecs[i].z);
      #1;
      check_obs($sformatf("vec%0d", i), vecs[i].exp);
      @(negedge clk);
    end

    // SW r2,3(r1), reset pulsed while waiting in MEM
    drive(24'h605003, 1'b1, 1'b0);
    #1;
    v = mk('h605003,1,0, 0,3,4,2, 0,0,0, 1,0,0, 1,1,0, 0, 8, 'h0);
    check_obs("sw_fetch", v.exp);
    @(negedge clk);
    #1;
    v = mk('h605003,1,0, 1,1,2,0, 0,0,0, 0,0,0, 0,0,0, 0, 8, 'h3);
    check_obs("sw_decode", v.exp);
    @(negedge clk);
    #1;
    v = mk('h605003,1,0, 2,1,2,0, 0,0,1, 0,0,0, 0,0,0, 0, 8, 'h3);
    check_obs("sw_exec", v.exp);
    @(negedge clk);
    drive(24'h000000, 1'b0, 1'b0);
    #1;
    v = mk(0,0,0, 3,1,2,0, 0,0,0, 0,1,0, 0,0,0, 0, 8, 'h3);
    check_obs("sw_mem_wait", v.exp);
    #1;
    reset = 1'b0;
    #1;
    check_obs("sw_reset_async", '0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check_obs("sw_reset_held", '0);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    v = mk(0,0,0, 0,0,0,0, 0,0,0, 1,0,0, 0,0,0, 0, 0, 'h0);
    check_obs("after_release", v.exp);
    @(negedge clk);
    #1;
    check_obs("after_release_hold", v.exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
